pool_ctrl: RTL and testbench

Sequencer for the 2x2, stride-2 max-pool stage of the CIFAR-10 pipeline. On start, it walks a C x H x W feature map held in the activation SRAM and issues four reads per output window. It then writes the signed maximum back to the output region and raises done. Its start/done pair drives the pool cycle counter directly: start is held high for the whole operation and done stays high until start drops.

---
 rtl/pool_pkg.sv | 26 ++
 rtl/pool_addr_gen.sv | 76 +++++++
 rtl/pool_ctrl.sv | 126 ++++++++++++
 tb/tb_pool_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared types, defaults and helpers for the max-pool sequencer
package pool_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 14;

   typedef enum logic [2:0] {
      IDLE,
      R0,
      R1,
      R2,
      R3,
      WR,
      DONE
   } state_t;

   // Bit i gives the column/row offset of the i-th read in a 2x2 window.
   localparam logic [3:0] WIN_DX = 4'b1010;
   localparam logic [3:0] WIN_DY = 4'b1100;

   function automatic logic signed [31:0] smax(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// rtl/pool_addr_gen.sv - window counters and SRAM address generation for pool_ctrl
module pool_addr_gen
   import pool_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DIM_W  = 6,
   parameter int CH_W   = 7
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              load,
   input  logic              step,
   input  logic [1:0]        phase,
   input  logic [DIM_W-1:0]  cfg_width,
   input  logic [DIM_W-1:0]  cfg_height,
   input  logic [CH_W-1:0]   cfg_channels,
   input  logic [ADDR_W-1:0] in_base,
   input  logic [ADDR_W-1:0] out_base,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              last_window
);

   logic [DIM_W-1:0]  w_r, h_r, ow, oh, ox, oy;
   logic [CH_W-1:0]   ch_r, c;
   logic [ADDR_W-1:0] ib_r, ob_r;

   assign ow = {1'b0, w_r[DIM_W-1:1]};
   assign oh = {1'b0, h_r[DIM_W-1:1]};

   assign last_window = (ox == ow - DIM_W'(1)) && (oy == oh - DIM_W'(1)) &&
                        (c == ch_r - CH_W'(1));

   // 32-bit intermediate then truncate: wrap modulo 2^ADDR_W is intended.
   assign rd_addr = ADDR_W'(32'(ib_r) + 32'(c) * 32'(w_r) * 32'(h_r) +
                            (32'({oy, 1'b0}) + 32'(WIN_DY[phase])) * 32'(w_r) +
                            32'({ox, 1'b0}) + 32'(WIN_DX[phase]));

   assign wr_addr = ADDR_W'(32'(ob_r) + 32'(c) * 32'(ow) * 32'(oh) +
                            32'(oy) * 32'(ow) + 32'(ox));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         w_r  <= '0;
         h_r  <= '0;
         ch_r <= '0;
         ib_r <= '0;
         ob_r <= '0;
         ox   <= '0;
         oy   <= '0;
         c    <= '0;
      end else if (load) begin
         w_r  <= cfg_width;
         h_r  <= cfg_height;
         ch_r <= cfg_channels;
         ib_r <= in_base;
         ob_r <= out_base;
         ox   <= '0;
         oy   <= '0;
         c    <= '0;
      end else if (step) begin
         if (ox == ow - DIM_W'(1)) begin
            ox <= '0;
            if (oy == oh - DIM_W'(1)) begin
               oy <= '0;
               c  <= c + CH_W'(1);
            end else begin
               oy <= oy + DIM_W'(1);
            end
         end else begin
            ox <= ox + DIM_W'(1);
         end
      end
   end

endmodule

// File: rtl/pool_ctrl.sv
// rtl/pool_ctrl.sv - 2x2 stride-2 max-pool sequencer (FSM + accumulator)
// Define POOL_RELU_EN to clamp negative pooled results to zero.
module pool_ctrl
   import pool_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DIM_W  = 6,
   parameter int CH_W   = 7
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     start,
   input  logic [DIM_W-1:0]         cfg_width,
   input  logic [DIM_W-1:0]         cfg_height,
   input  logic [CH_W-1:0]          cfg_channels,
   input  logic [ADDR_W-1:0]        in_base,
   input  logic [ADDR_W-1:0]        out_base,
   output logic                     rd_en,
   output logic [ADDR_W-1:0]        rd_addr,
   input  logic signed [DATA_W-1:0] rd_data,
   output logic                     wr_en,
   output logic [ADDR_W-1:0]        wr_addr,
   output logic [DATA_W-1:0]        wr_data,
   output logic                     busy,
   output logic                     done
);

   state_t                   state, state_nx;
   logic                     load, step, cfg_ok, last_window;
   logic [1:0]               phase;
   logic [ADDR_W-1:0]        rd_addr_g, wr_addr_g;
   logic signed [DATA_W-1:0] acc, wmax, pooled;

   assign cfg_ok = (cfg_width[DIM_W-1:1] != '0) && (cfg_height[DIM_W-1:1] != '0) &&
                   (cfg_channels != '0);

   pool_addr_gen #(
      .ADDR_W (ADDR_W),
      .DIM_W  (DIM_W),
      .CH_W   (CH_W)
   ) u_addr_gen (
      .clk          (clk),
      .rstn         (rstn),
      .load         (load),
      .step         (step),
      .phase        (phase),
      .cfg_width    (cfg_width),
      .cfg_height   (cfg_height),
      .cfg_channels (cfg_channels),
      .in_base      (in_base),
      .out_base     (out_base),
      .rd_addr      (rd_addr_g),
      .wr_addr      (wr_addr_g),
      .last_window  (last_window)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      step     = 1'b0;
      phase    = 2'd0;
      rd_en    = 1'b0;
      wr_en    = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (cfg_ok) begin
                  state_nx = R0;
                  load     = 1'b1;
               end else begin
                  state_nx = DONE;
               end
            end
         end
         R0: begin rd_en = 1'b1; busy = 1'b1; phase = 2'd0; state_nx = R1; end
         R1: begin rd_en = 1'b1; busy = 1'b1; phase = 2'd1; state_nx = R2; end
         R2: begin rd_en = 1'b1; busy = 1'b1; phase = 2'd2; state_nx = R3; end
         R3: begin rd_en = 1'b1; busy = 1'b1; phase = 2'd3; state_nx = WR; end
         WR: begin
            wr_en    = 1'b1;
            busy     = 1'b1;
            step     = 1'b1;
            state_nx = last_window ? DONE : R0;
         end
         DONE: begin
            done = 1'b1;
            if (!start) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // rd_data trails rd_en by one cycle, so R1 sees the R0 word.
   assign wmax = DATA_W'(smax(32'(acc), 32'(rd_data)));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc <= '0;
      end else begin
         case (state)
            R1:      acc <= rd_data;
            R2, R3:  acc <= wmax;
            default: ;
         endcase
      end
   end

`ifdef POOL_RELU_EN
   assign pooled = wmax[DATA_W-1] ? '0 : wmax;
`else
   assign pooled = wmax;
`endif

   assign rd_addr = rd_en ? rd_addr_g : '0;
   assign wr_addr = wr_en ? wr_addr_g : '0;
   assign wr_data = wr_en ? pooled : '0;

endmodule

// File: tb/tb_pool_ctrl.sv
// tb/tb_pool_ctrl.sv - self-checking bench for pool_ctrl with an SRAM and window model
module tb_pool_ctrl;

   localparam int MASK = 16'h3FFF;

   logic              clk = 1'b0;
   logic              rstn;
   logic              start;
   logic [5:0]        cfg_width;
   logic [5:0]        cfg_height;
   logic [6:0]        cfg_channels;
   logic [13:0]       in_base;
   logic [13:0]       out_base;
   logic              rd_en;
   logic [13:0]       rd_addr;
   logic signed [7:0] rd_data = '0;
   logic              wr_en;
   logic [13:0]       wr_addr;
   logic [7:0]        wr_data;
   logic              busy;
   logic              done;

   logic signed [7:0] mem [0:16383];
   int exp_rd[$];
   int exp_wa[$];
   int exp_wd[$];
   int act_wa[$];
   int act_wd[$];
   int vectors = 0;
   int miscompares = 0;
   bit checking = 1'b0;

   pool_ctrl dut (
      .clk          (clk),
      .rstn         (rstn),
      .start        (start),
      .cfg_width    (cfg_width),
      .cfg_height   (cfg_height),
      .cfg_channels (cfg_channels),
      .in_base      (in_base),
      .out_base     (out_base),
      .rd_en        (rd_en),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   // SRAM: one-cycle read latency.
   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Expected read and write streams derived directly from the pooling rules.
   task automatic build(input int w, input int h, input int c, input int ib, input int ob);
      int ow, oh, m, a, v;
      exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
      ow = w / 2;
      oh = h / 2;
      if (ow == 0 || oh == 0 || c == 0) return;
      for (int ch = 0; ch < c; ch++)
         for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++) begin
               m = -1000;
               for (int dy = 0; dy < 2; dy++)
                  for (int dx = 0; dx < 2; dx++) begin
                     a = (ib + ch * w * h + (2 * oy + dy) * w + 2 * ox + dx) & MASK;
                     exp_rd.push_back(a);
                     v = int'(mem[a]);
                     if (v > m) m = v;
                  end
`ifdef POOL_RELU_EN
               if (m < 0) m = 0;
`endif
               exp_wa.push_back((ob + ch * ow * oh + oy * ow + ox) & MASK);
               exp_wd.push_back(m);
            end
   endtask

   always @(negedge clk) begin
      if (checking && rstn) begin
         chk("rd_wr_exclusive", int'(rd_en & wr_en), 0);
         if (rd_en) begin
            if (exp_rd.size() == 0) chk("rd_unexpected", int'(rd_addr), -1);
            else                    chk("rd_addr", int'(rd_addr), exp_rd.pop_front());
         end
         if (wr_en) begin
            act_wa.push_back(int'(wr_addr));
            act_wd.push_back(int'($signed(wr_data)));
            if (exp_wa.size() == 0) begin
               chk("wr_unexpected", int'(wr_addr), -1);
            end else begin
               chk("wr_addr", int'(wr_addr), exp_wa.pop_front());
               chk("wr_data", int'($signed(wr_data)), exp_wd.pop_front());
            end
         end
      end
   end

   task automatic chk_quiet(input string tag);
      chk({tag, "_rd_en"}, int'(rd_en), 0);
      chk({tag, "_wr_en"}, int'(wr_en), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_rd_addr"}, int'(rd_addr), 0);
      chk({tag, "_wr_addr"}, int'(wr_addr), 0);
      chk({tag, "_wr_data"}, int'(wr_data), 0);
   endtask

   task automatic run_op(input int w, input int h, input int c, input int ib, input int ob,
                         input int drop_at);
      int n, cyc, expc;
      build(w, h, c, ib, ob);
      n = exp_wa.size();
      act_wa.delete(); act_wd.delete();
      expc = 5 * n + 1;
      cfg_width = 6'(w); cfg_height = 6'(h); cfg_channels = 7'(c);
      in_base = 14'(ib); out_base = 14'(ob);
      checking = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      cfg_width = 6'd3; cfg_height = 6'd9; cfg_channels = 7'd5;
      in_base = 14'h1234; out_base = 14'h0777;
      cyc = 1;
      while (!done && cyc < expc + 20) begin
         if (drop_at != 0 && cyc == drop_at) start = 1'b0;
         @(posedge clk); #1;
         cyc++;
      end
      chk("done_latency", cyc, expc);
      chk("done_level", int'(done), 1);
      chk("busy_in_done", int'(busy), 0);
      if (start) begin
         repeat (2) begin
            @(posedge clk); #1;
            chk("done_hold", int'(done), 1);
         end
      end
      start = 1'b0;
      @(posedge clk); #1;
      chk("done_clear", int'(done), 0);
      chk("busy_idle", int'(busy), 0);
      chk("rd_left", exp_rd.size(), 0);
      chk("wr_left", exp_wa.size(), 0);
   endtask

   task automatic fill_ramp16();
      for (int i = 0; i < 16; i++) mem[i] = 8'(i);
   endtask

   task automatic chk_ramp16_writes(input string tag);
      chk({tag, "_count"}, act_wa.size(), 4);
      for (int i = 0; i < 4; i++) chk({tag, "_addr"}, act_wa[i], 100 + i);
      chk({tag, "_d0"}, act_wd[0], 5);
      chk({tag, "_d1"}, act_wd[1], 7);
      chk({tag, "_d2"}, act_wd[2], 13);
      chk({tag, "_d3"}, act_wd[3], 15);
   endtask

   initial begin
      int neg_exp, ch1_exp;
      rstn = 1'b0; start = 1'b0;
      cfg_width = '0; cfg_height = '0; cfg_channels = '0; in_base = '0; out_base = '0;
      for (int i = 0; i < 16384; i++) mem[i] = '0;
      repeat (2) @(posedge clk);
      #1 chk_quiet("reset");
      #2 rstn = 1'b1;
      @(posedge clk); #1;
      chk_quiet("post_reset");

      // 4x4x1 ramp, start held through DONE
      fill_ramp16();
      run_op(4, 4, 1, 0, 100, 0);
      chk_ramp16_writes("ramp");

      // 4x2x2 wrapping the 14-bit address space on both read and write sides
      begin
         int v0 [8] = '{10, -20, 30, 1, 2, 50, -7, 4};
         for (int i = 0; i < 8; i++) mem[16376 + i] = 8'(v0[i]);
         for (int i = 0; i < 8; i++) mem[i] = -8'sd128;
         mem[6] = 8'sd3;
      end
      run_op(4, 2, 2, 14'h3FF8, 14'h3FFF, 0);
`ifdef POOL_RELU_EN
      ch1_exp = 0;
`else
      ch1_exp = -128;
`endif
      chk("wrap_count", act_wa.size(), 4);
      chk("wrap_a0", act_wa[0], 16383);
      chk("wrap_a1", act_wa[1], 0);
      chk("wrap_a3", act_wa[3], 2);
      chk("wrap_d0", act_wd[0], 50);
      chk("wrap_d1", act_wd[1], 30);
      chk("wrap_d2", act_wd[2], ch1_exp);
      chk("wrap_d3", act_wd[3], 3);

      // 5x5x1: odd row/column dropped; they hold 127 so any stray read shows
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++)
            mem[200 + y * 5 + x] = (y == 4 || x == 4) ? 8'sd127 : 8'(y * 5 + x - 12);
      run_op(5, 5, 1, 200, 300, 0);
      chk("odd_count", act_wa.size(), 4);
      chk("odd_d3", act_wd[3], 6);

      // degenerate maps: no SRAM access, done one cycle after start
      run_op(1, 4, 1, 0, 400, 0);
      run_op(4, 4, 0, 0, 400, 0);
      run_op(4, 1, 2, 0, 400, 0);
      chk("degen_writes", act_wa.size(), 0);

      // all-negative window, start dropped mid-operation
      mem[50] = -8'sd5; mem[51] = -8'sd3; mem[52] = -8'sd9; mem[53] = -8'sd7;
      run_op(2, 2, 1, 50, 60, 2);
`ifdef POOL_RELU_EN
      neg_exp = 0;
`else
      neg_exp = -3;
`endif
      chk("neg_count", act_wa.size(), 1);
      chk("neg_data", act_wd[0], neg_exp);
      chk("neg_addr", act_wa[0], 60);

      // reset pulse while in R2, then a clean full pass
      fill_ramp16();
      build(4, 4, 1, 0, 100);
      cfg_width = 6'd4; cfg_height = 6'd4; cfg_channels = 7'd1;
      in_base = '0; out_base = 14'd100;
      checking = 1'b1;
      start = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      chk("r2_busy", int'(busy), 1);
      chk("r2_rd_en", int'(rd_en), 1);
      checking = 1'b0;
      #1 rstn = 1'b0;
      #1 chk_quiet("mid_reset");
      start = 1'b0;
      @(posedge clk); #1;
      chk_quiet("held_reset");
      rstn = 1'b1;
      @(posedge clk); #1;
      chk_quiet("after_reset");
      run_op(4, 4, 1, 0, 100, 0);
      chk_ramp16_writes("rerun");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
